// File: rtl/stream_arb_mux.sv
// N-input stream multiplexer with round-robin or fixed-priority arbitration
// and a registered output stage that tags each beat with its source index.
module stream_arb_mux #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned N_INP  = 2,
    parameter int unsigned RR_ARB = 1,
    parameter int unsigned IDX_W  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_INP-1:0][DATA_W-1:0]   inp_data_i,
    input  logic [N_INP-1:0]               inp_valid_i,
    output logic [N_INP-1:0]               inp_ready_o,
    output logic [DATA_W-1:0]              oup_data_o,
    output logic [IDX_W-1:0]               oup_idx_o,
    output logic                           oup_valid_o,
    input  logic                           oup_ready_i
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   pos;
    logic             any_valid;
    logic             load_en;

    assign load_en = ~oup_valid_o | oup_ready_i;

    // Search upward from base with wrap; fixed priority is the base=0 case.
    always_comb begin
        base      = (RR_ARB != 0) ? ptr : '0;
        grant     = '0;
        cand      = '0;
        pos       = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < N_INP; k++) begin
            pos = {1'b0, base} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N_INP)) begin
                pos = pos - (IDX_W+1)'(N_INP);
            end
            cand = pos[IDX_W-1:0];
            if (!any_valid && inp_valid_i[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        inp_ready_o = '0;
        if (any_valid) begin
            inp_ready_o[grant] = load_en;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oup_valid_o <= 1'b0;
            oup_data_o  <= '0;
            oup_idx_o   <= '0;
            ptr         <= '0;
        end else if (load_en) begin
            if (any_valid) begin
                oup_valid_o <= 1'b1;
                oup_data_o  <= inp_data_i[grant];
                oup_idx_o   <= grant;
                ptr         <= (grant == IDX_W'(N_INP - 1)) ? '0 : grant + 1'b1;
            end else begin
                oup_valid_o <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    if (N_INP < 1) begin : g_bad_n_inp
        $fatal(1, "stream_arb_mux: N_INP must be >= 1");
    end

    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(inp_ready_o));

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (oup_valid_o && !oup_ready_i) |=>
            (oup_valid_o && $stable(oup_data_o) && $stable(oup_idx_o)));
`endif

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: a round-robin and a fixed-priority
// instance share one set of 4-input stimulus with hand-computed expectations.
module tb_stream_arb_mux;

    logic             clk;
    logic             rst_n;
    logic [3:0][7:0]  in_data;
    logic [3:0]       in_valid;
    logic             out_ready;

    logic [3:0]       rr_ready;
    logic [7:0]       rr_data;
    logic [1:0]       rr_idx;
    logic             rr_valid;

    logic [3:0]       fp_ready;
    logic [7:0]       fp_data;
    logic [1:0]       fp_idx;
    logic             fp_valid;

    int unsigned      n_vec  = 0;
    int unsigned      n_miss = 0;

    stream_arb_mux #(.DATA_W(8), .N_INP(4), .RR_ARB(1)) dut_rr (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .inp_data_i  (in_data),
        .inp_valid_i (in_valid),
        .inp_ready_o (rr_ready),
        .oup_data_o  (rr_data),
        .oup_idx_o   (rr_idx),
        .oup_valid_o (rr_valid),
        .oup_ready_i (out_ready)
    );

    stream_arb_mux #(.DATA_W(8), .N_INP(4), .RR_ARB(0)) dut_fp (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .inp_data_i  (in_data),
        .inp_valid_i (in_valid),
        .inp_ready_o (fp_ready),
        .oup_data_o  (fp_data),
        .oup_idx_o   (fp_idx),
        .oup_valid_o (fp_valid),
        .oup_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rr_out(input string tag, input logic [7:0] data, input logic [1:0] idx);
        check_val({tag, "_valid"}, 32'(rr_valid), 32'd1);
        check_val({tag, "_data"},  32'(rr_data),  32'(data));
        check_val({tag, "_idx"},   32'(rr_idx),   32'(idx));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) in_data[i] = 8'hA0 + 8'(i);
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;

        // Reset then idle
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_rr_valid", 32'(rr_valid), 32'd0);
        check_val("rst_rr_data",  32'(rr_data),  32'd0);
        check_val("rst_rr_idx",   32'(rr_idx),   32'd0);
        check_val("rst_rr_ready", 32'(rr_ready), 32'd0);
        check_val("rst_fp_valid", 32'(fp_valid), 32'd0);
        check_val("rst_fp_ready", 32'(fp_ready), 32'd0);
        rst_n = 1'b1;

        // Round-robin fairness: grants 0,1,2,3,0,1 at one beat per cycle
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = 4'b1111;
            #1;
            if (k > 0) check_rr_out("rr_fair", 8'hA0 + 8'((k - 1) % 4), 2'((k - 1) % 4));
            check_val("rr_fair_ready", 32'(rr_ready), 32'(1 << (k % 4)));
        end

        // Pointer skip and wrap: last grant 1, only inputs 0 and 3 valid
        @(negedge clk);
        in_valid = 4'b1001;
        #1;
        check_rr_out("rr_last1", 8'hA1, 2'd1);
        check_val("rr_skip_ready", 32'(rr_ready), 32'b1000);
        @(negedge clk);
        #1;
        check_rr_out("rr_skip", 8'hA3, 2'd3);
        check_val("rr_wrap_ready", 32'(rr_ready), 32'b0001);
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        check_rr_out("rr_wrap", 8'hA0, 2'd0);
        check_val("rr_idle_ready", 32'(rr_ready), 32'd0);
        @(negedge clk);
        #1;
        check_val("rr_drain_valid", 32'(rr_valid), 32'd0);
        check_val("rr_drain_data",  32'(rr_data),  32'hA0);

        // Fixed priority: inputs 1 and 2 valid, input 1 always wins
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 4'b0110;
            #1;
            if (k > 0) begin
                check_val("fp_data", 32'(fp_data), 32'hA1);
                check_val("fp_idx",  32'(fp_idx),  32'd1);
            end
            check_val("fp_ready", 32'(fp_ready), 32'b0010);
        end
        @(negedge clk);
        in_valid = 4'b0100;
        #1;
        check_val("fp_data_last1", 32'(fp_data), 32'hA1);
        check_val("fp_ready_in2",  32'(fp_ready), 32'b0100);
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        check_val("fp_data_in2",  32'(fp_data),  32'hA2);
        check_val("fp_idx_in2",   32'(fp_idx),   32'd2);
        check_val("fp_valid_in2", 32'(fp_valid), 32'd1);

        // RR pointer is now 3; a lone input 0 loads one beat
        @(negedge clk);
        in_valid = 4'b0001;
        #1;
        check_val("rr_ptr3_ready", 32'(rr_ready), 32'b0001);

        // Backpressure for 5 cycles
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 4'b1111;
            #1;
            check_rr_out("bp_hold", 8'hA0, 2'd0);
            check_val("bp_rr_ready", 32'(rr_ready), 32'd0);
            check_val("bp_fp_ready", 32'(fp_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_rr_out("bp_release", 8'hA0, 2'd0);
        check_val("bp_release_ready", 32'(rr_ready), 32'b0010);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check_rr_out("bp_refill", 8'hA1, 2'd1);

        // Reset asserted mid-stall clears the held beat without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(rr_valid), 32'd0);
        check_val("mid_rst_data",  32'(rr_data),  32'd0);
        check_val("mid_rst_idx",   32'(rr_idx),   32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1010;
        #1;
        check_val("post_rst_ready", 32'(rr_ready), 32'b0010);
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        check_rr_out("post_rst", 8'hA1, 2'd1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
